// File: rtl/ntt_frame_serializer.sv
// ntt_frame_serializer: captures a full parallel coefficient frame in one cycle and streams it
// word by word over valid/ready, with a two-deep ping-pong buffer so the next frame can land early.
module ntt_frame_serializer #(
  parameter int DATA_WIDTH_PER_INPUT = 28,
  parameter int INPUT_PER_CYCLE      = 128,
  localparam int IDX_W = $clog2(INPUT_PER_CYCLE)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            frame_valid,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] frame_data [INPUT_PER_CYCLE],
  output logic                            frame_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH_PER_INPUT-1:0] out_data,
  output logic [IDX_W-1:0]                out_index,
  output logic                            out_last,
  output logic                            overflow
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            wr_sel_q, rd_sel_q, overflow_q;
  logic                            hs, last_hs, cap;
  logic [DATA_WIDTH_PER_INPUT-1:0] buf_q [2][INPUT_PER_CYCLE];

  always_comb begin
    out_valid   = state_q != EMPTY;
    out_last    = out_valid & (idx_q == IDX_W'(INPUT_PER_CYCLE - 1));
    hs          = out_valid & out_ready;
    last_hs     = hs & out_last;
    frame_ready = (state_q != TWO) | last_hs;
    cap         = frame_valid & frame_ready;
    idx_d       = last_hs ? '0 : idx_q + IDX_W'(hs);
    state_d     = (cap && !last_hs) ? ((state_q == EMPTY) ? ONE : TWO) :
                  (!cap && last_hs) ? ((state_q == TWO) ? ONE : EMPTY) : state_q;
    out_data    = out_valid ? buf_q[rd_sel_q][idx_q] : '0;
    out_index   = idx_q;
    overflow    = overflow_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      idx_q      <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_sel_q   <= wr_sel_q ^ cap;
      rd_sel_q   <= rd_sel_q ^ last_hs;
      overflow_q <= overflow_q | (frame_valid & ~frame_ready);
    end
  end

  // In TWO with a last handshake, wr_sel points at the buffer just drained, so overwriting is safe.
  always_ff @(posedge clk) begin
    if (cap)
      for (int i = 0; i < INPUT_PER_CYCLE; i++) buf_q[wr_sel_q][i] <= frame_data[i];
  end
endmodule

// File: tb/tb_ntt_frame_serializer.sv
// tb_ntt_frame_serializer: randomized bench against a queue-based model of the frame stream.
module tb_ntt_frame_serializer;
  localparam int DW = 28, N = 128;
  typedef struct packed {logic [31:0] data; logic [31:0] idx; logic last; logic [31:0] cyc;} ev_t;

  logic clk = 0, rst = 1, frame_valid = 0, out_ready = 0;
  logic [DW-1:0] fdata [N];
  logic frame_ready, out_valid, out_last, overflow;
  logic [DW-1:0] out_data;
  logic [6:0] out_index;

  int n_checks = 0, n_fail = 0, cyc = 0;
  bit exp_fr, exp_ovf, s_fr, s_valid, s_last;
  logic [DW-1:0] s_data;
  logic [6:0] s_idx;
  ev_t mq[$], ex[$], got[$];

  ntt_frame_serializer #(.DATA_WIDTH_PER_INPUT(DW), .INPUT_PER_CYCLE(N)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(fdata), .frame_ready(frame_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .overflow(overflow));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && out_valid && out_ready)
      got.push_back(ev_t'{32'(out_data), 32'(out_index), out_last, 32'(cyc)});

  // Model: mq holds every accepted word still owed downstream, oldest first.
  task automatic cycle(input bit fv, input bit rdy);
    ev_t e;
    frame_valid = fv;
    out_ready   = rdy;
    exp_fr = (mq.size() <= N) || (rdy && mq.size() > 0 && mq[0].idx == N - 1);
    if (rdy && mq.size() > 0) begin
      e = mq.pop_front();
      e.cyc = cyc;
      ex.push_back(e);
    end
    if (fv) begin
      if (exp_fr) for (int i = 0; i < N; i++) mq.push_back(ev_t'{32'(fdata[i]), 32'(i), i == N - 1, 32'd0});
      else exp_ovf = 1;
    end
    @(negedge clk);
    s_fr = frame_ready; s_valid = out_valid; s_data = out_data; s_idx = out_index; s_last = out_last;
    @(posedge clk);
    #1;
    cyc++;
    frame_valid = 0;
  endtask

  task automatic apply_reset;
    rst = 1; frame_valid = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    mq.delete(); ex.delete(); got.delete();
    exp_ovf = 0;
  endtask

  task automatic drain;
    for (int k = 0; k < 4 * N && mq.size() > 0; k++) cycle(0, 1);
    repeat (3) cycle(0, 1);
  endtask

  task automatic rand_frame;
    for (int i = 0; i < N; i++) fdata[i] = DW'($urandom);
  endtask

  task automatic test_reset;
    apply_reset();
    n_checks++;
    if (out_valid !== 0 || out_index !== 0 || out_last !== 0 || frame_ready !== 1 || out_data !== 0 || overflow !== 0) begin
      n_fail++;
      $display("FAIL reset v=%b i=%0d l=%b fr=%b d=%0d ovf=%b want 0 0 0 1 0 0",
               out_valid, out_index, out_last, frame_ready, out_data, overflow);
    end
  endtask

  task automatic test_single;
    apply_reset();
    for (int i = 0; i < N; i++) fdata[i] = DW'(i + 1);
    cycle(1, 1);
    n_checks++;
    if (out_valid !== 1 || out_index !== 0 || out_data !== 1) begin
      n_fail++;
      $display("FAIL single_latency v=%b i=%0d d=%0d want 1 0 1", out_valid, out_index, out_data);
    end
    drain();
    n_checks++;
    if (got.size() != N || ex.size() != N) begin
      n_fail++;
      $display("FAIL single_count got %0d want %0d", got.size(), N);
    end
    for (int k = 0; k < ex.size() && k < got.size(); k++) begin
      n_checks++;
      if (got[k] !== ex[k]) begin n_fail++; $display("FAIL single_word%0d got %h want %h", k, got[k], ex[k]); end
    end
    n_checks++;
    if (out_valid !== 0) begin n_fail++; $display("FAIL single_idle out_valid %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    for (int i = 0; i < N; i++) fdata[i] = DW'(i);
    cycle(1, 1);
    repeat (N - 1) cycle(0, 1);
    for (int i = 0; i < N; i++) fdata[i] = DW'(1000 + i);
    cycle(1, 1);
    drain();
    n_checks++;
    if (got.size() != 2 * N || ex.size() != 2 * N) begin
      n_fail++;
      $display("FAIL b2b_count got %0d want %0d", got.size(), 2 * N);
    end
    for (int k = 0; k < ex.size() && k < got.size(); k++) begin
      n_checks++;
      if (got[k] !== ex[k] || got[k].cyc != got[0].cyc + k) begin
        n_fail++; $display("FAIL b2b_word%0d got %h want %h", k, got[k], ex[k]);
      end
    end
    n_checks++;
    if (overflow !== 0) begin n_fail++; $display("FAIL b2b_overflow got %b want 0", overflow); end
  endtask

  task automatic test_backpressure;
    bit pv = 0, prdy = 1, pl = 0, rdy;
    logic [DW-1:0] pd = '0;
    logic [6:0] pi = '0;
    apply_reset();
    rand_frame();
    for (int k = 0; k < 2000 && (k < 12 || mq.size() > 0); k++) begin
      rdy = (k % 4 == 0) || (k % 4 == 3);
      if (k == 10) rand_frame();
      cycle(k == 0 || k == 10, rdy);
      if (pv && !prdy) begin
        n_checks++;
        if (s_valid !== 1 || s_data !== pd || s_idx !== pi || s_last !== pl) begin
          n_fail++;
          $display("FAIL bp_stall k=%0d got v=%b d=%h i=%0d want v=1 d=%h i=%0d", k, s_valid, s_data, s_idx, pd, pi);
        end
      end
      pv = s_valid; prdy = rdy; pd = s_data; pi = s_idx; pl = s_last;
    end
    drain();
    n_checks++;
    if (got.size() != ex.size() || ex.size() != 2 * N) begin
      n_fail++;
      $display("FAIL bp_count got %0d want %0d", got.size(), 2 * N);
    end
    for (int k = 0; k < ex.size() && k < got.size(); k++) begin
      n_checks++;
      if (got[k] !== ex[k]) begin n_fail++; $display("FAIL bp_word%0d got %h want %h", k, got[k], ex[k]); end
    end
  endtask

  task automatic test_overflow;
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      cycle(1, 0);
      n_checks++;
      if (s_fr !== exp_fr) begin n_fail++; $display("FAIL ovf_ready%0d got %b want %b", f, s_fr, exp_fr); end
    end
    n_checks++;
    if (overflow !== exp_ovf || exp_ovf !== 1) begin
      n_fail++; $display("FAIL ovf_flag got %b want 1", overflow);
    end
    drain();
    n_checks++;
    if (got.size() != ex.size() || ex.size() != 2 * N) begin
      n_fail++;
      $display("FAIL ovf_count got %0d want %0d", got.size(), 2 * N);
    end
    for (int k = 0; k < ex.size() && k < got.size(); k++) begin
      n_checks++;
      if (got[k] !== ex[k]) begin n_fail++; $display("FAIL ovf_word%0d got %h want %h", k, got[k], ex[k]); end
    end
  endtask

  task automatic test_boundary;
    apply_reset();
    rand_frame(); cycle(1, 0);
    rand_frame(); cycle(1, 0);
    repeat (N - 1) cycle(0, 1);
    rand_frame();
    cycle(1, 1);
    n_checks++;
    if (s_fr !== exp_fr || exp_fr !== 1) begin n_fail++; $display("FAIL bound_ready got %b want 1", s_fr); end
    n_checks++;
    if (overflow !== 0) begin n_fail++; $display("FAIL bound_overflow got %b want 0", overflow); end
    drain();
    n_checks++;
    if (got.size() != ex.size() || ex.size() != 3 * N) begin
      n_fail++;
      $display("FAIL bound_count got %0d want %0d", got.size(), 3 * N);
    end
    for (int k = 0; k < ex.size() && k < got.size(); k++) begin
      n_checks++;
      if (got[k] !== ex[k]) begin n_fail++; $display("FAIL bound_word%0d got %h want %h", k, got[k], ex[k]); end
    end
  endtask

  task automatic test_async_reset;
    apply_reset();
    rand_frame();
    cycle(1, 1);
    repeat (50) cycle(0, 1);
    n_checks++;
    if (out_index !== 50 || out_valid !== 1) begin
      n_fail++; $display("FAIL areset_pre i=%0d v=%b want 50 1", out_index, out_valid);
    end
    #2 rst = 1;
    #1;
    n_checks++;
    if (out_valid !== 0 || out_index !== 0 || out_last !== 0) begin
      n_fail++; $display("FAIL areset_now v=%b i=%0d l=%b want 0 0 0", out_valid, out_index, out_last);
    end
    @(posedge clk);
    #1;
    rst = 0;
    mq.delete(); ex.delete(); got.delete();
    exp_ovf = 0;
    rand_frame();
    cycle(1, 1);
    n_checks++;
    if (out_valid !== 1 || out_index !== 0) begin
      n_fail++; $display("FAIL areset_restart v=%b i=%0d want 1 0", out_valid, out_index);
    end
    drain();
    n_checks++;
    if (got.size() != ex.size() || ex.size() != N) begin
      n_fail++;
      $display("FAIL areset_count got %0d want %0d", got.size(), N);
    end
    for (int k = 0; k < ex.size() && k < got.size(); k++) begin
      n_checks++;
      if (got[k] !== ex[k]) begin n_fail++; $display("FAIL areset_word%0d got %h want %h", k, got[k], ex[k]); end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) fdata[i] = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_boundary();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
